// File: rtl/ysyx_22050133_lsu.sv
// Load/store unit: one aligned 64-bit bus transaction per instruction, returns write-back value.
// Latency 1 cycle (pass-through/error) or 3+ cycles (memory); input stalls until the output handshake completes.
module ysyx_22050133_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  ctrl_mem,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic        req_we_q;
  logic [63:0] req_addr_q;
  logic [63:0] req_wdata_q;
  logic [7:0]  req_wmask_q;
  logic [63:0] out_data_q;
  logic        out_err_q;

  logic        is_ld, is_st, is_mem;
  logic [2:0]  f3;
  logic        illegal, misaligned, dec_err;
  logic [7:0]  st_mask;
  logic        accept;
  logic [63:0] lane;
  logic [63:0] ld_data;

  assign is_ld  = ctrl_mem[4];
  assign is_st  = ctrl_mem[3];
  assign f3     = ctrl_mem[2:0];
  assign is_mem = is_ld | is_st;
  assign accept = (state_q == S_IDLE) && in_valid;

  // Decode of the incoming instruction; only consumed on the accept edge.
  always_comb begin
    illegal    = (is_ld && is_st) || (is_ld && f3 == 3'b111) || (is_st && f3[2]);
    misaligned = 1'b0;
    st_mask    = 8'h00;
    case (f3[1:0])
      2'b00: st_mask = 8'h01 << addr[2:0];
      2'b01: begin
        misaligned = addr[0];
        st_mask    = 8'h03 << addr[2:0];
      end
      2'b10: begin
        misaligned = |addr[1:0];
        st_mask    = 8'h0F << addr[2:0];
      end
      default: begin
        misaligned = |addr[2:0];
        st_mask    = 8'hFF;
      end
    endcase
    dec_err = is_mem && (illegal || misaligned);
  end

  assign lane = mem_rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_data = mem_rsp_rdata;
    case (f3_q)
      3'b000:  ld_data = {{56{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{48{lane[15]}}, lane[15:0]};
      3'b010:  ld_data = {{32{lane[31]}}, lane[31:0]};
      3'b100:  ld_data = {56'd0, lane[7:0]};
      3'b101:  ld_data = {48'd0, lane[15:0]};
      3'b110:  ld_data = {32'd0, lane[31:0]};
      default: ld_data = mem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = (!is_mem || dec_err) ? S_RESP : S_REQ;
      S_REQ:   if (mem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (mem_rsp_valid) state_d = S_RESP;
      S_RESP:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_q        <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 3'd0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 64'd0;
      req_wdata_q <= 64'd0;
      req_wmask_q <= 8'd0;
      out_data_q  <= 64'd0;
      out_err_q   <= 1'b0;
    end else if (accept) begin
      ld_q       <= is_ld;
      f3_q       <= f3;
      off_q      <= addr[2:0];
      out_err_q  <= dec_err;
      out_data_q <= is_mem ? 64'd0 : addr;
      // Bus fields only change when a request is actually going out.
      if (is_mem && !dec_err) begin
        req_we_q    <= is_st;
        req_addr_q  <= {addr[63:3], 3'b000};
        req_wdata_q <= is_st ? (wdata << {addr[2:0], 3'b000}) : 64'd0;
        req_wmask_q <= is_st ? st_mask : 8'd0;
      end
    end else if (state_q == S_WAIT && mem_rsp_valid) begin
      out_data_q <= ld_q ? ld_data : 64'd0;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign out_valid     = (state_q == S_RESP);
  assign out_data      = out_data_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Directed + randomized bench for ysyx_22050133_lsu with a rule-level reference model and a scripted bus.
module tb_ysyx_22050133_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  ctrl_mem;
  logic [63:0] addr, wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        out_valid, out_ready, out_err;
  logic [63:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22050133_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .ctrl_mem(ctrl_mem),
    .addr(addr), .wdata(wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: pick the accessed bytes arithmetically, then extend.
  function automatic logic [63:0] load_val(input logic [63:0] rd, input logic [2:0] f3, input int off);
    int nb = 1 << f3[1:0];
    logic [63:0] lane = rd >> (off * 8);
    logic [63:0] m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
    logic [63:0] v = lane & m;
    if (!f3[2] && nb < 8 && v[nb*8-1]) v = v | ~m;
    return v;
  endfunction

  task automatic run_op(input logic [4:0] c, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rd, input int req_stall, input int rsp_delay,
                        input int out_stall, output logic [63:0] got);
    logic ld = c[4];
    logic st = c[3];
    logic [2:0] f3 = c[2:0];
    int nb = 1 << f3[1:0];
    int off = int'(a[2:0]);
    logic illegal = (ld && st) || (ld && f3 == 3'b111) || (st && f3[2]);
    logic mis = (ld || st) && ((a & 64'(nb - 1)) != 64'd0);
    logic exp_err = (ld || st) && (illegal || mis);
    logic is_mem = (ld || st) && !exp_err;
    logic [63:0] exp_data;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wd;

    exp_mask = st ? ((nb == 8) ? 8'hFF : 8'(((1 << nb) - 1) << off)) : 8'h00;
    exp_wd   = st ? (wd << (off * 8)) : 64'd0;
    if (!ld && !st)   exp_data = a;
    else if (exp_err) exp_data = 64'd0;
    else if (st)      exp_data = 64'd0;
    else              exp_data = load_val(rd, f3, off);

    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; ctrl_mem = c; addr = a; wdata = wd;
    @(negedge clk);
    in_valid = 1'b0; ctrl_mem = $urandom(); addr = {$urandom(), $urandom()}; wdata = {$urandom(), $urandom()};

    if (is_mem) begin
      for (int i = 0; i <= req_stall; i++) begin
        chk("req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("req_we", {63'd0, mem_req_we}, {63'd0, st});
        chk("req_addr", mem_req_addr, {a[63:3], 3'b000});
        chk("req_wmask", {56'd0, mem_req_wmask}, {56'd0, exp_mask});
        chk("req_wdata", mem_req_wdata, exp_wd);
        chk("out_valid_req", {63'd0, out_valid}, 64'd0);
        if (i == req_stall) begin
          mem_req_ready = 1'b1;
          mem_rsp_valid = 1'b1;  // same-cycle response must be ignored
          mem_rsp_rdata = ~rd;
        end
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      for (int i = 0; i <= rsp_delay; i++) begin
        chk("req_valid_wait", {63'd0, mem_req_valid}, 64'd0);
        chk("out_valid_wait", {63'd0, out_valid}, 64'd0);
        if (i == rsp_delay) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = rd;
        end
        @(negedge clk);
      end
      mem_rsp_valid = 1'b0;
    end else begin
      chk("req_valid_none", {63'd0, mem_req_valid}, 64'd0);
    end

    got = out_data;
    for (int i = 0; i <= out_stall; i++) begin
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("out_data", out_data, exp_data);
      chk("out_err", {63'd0, out_err}, {63'd0, exp_err});
      chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
      if (i == out_stall) begin
        out_ready = 1'b1;
        in_valid  = 1'b1;  // must not be taken in the retire cycle
        ctrl_mem  = 5'd0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_retired", {63'd0, out_valid}, 64'd0);
    chk("in_ready_after", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] a, wd, rd;
    logic [4:0]  c;
    int nb;

    rst = 1'b0; in_valid = 1'b0; ctrl_mem = 5'd0; addr = 64'd0; wdata = 64'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_req_we", {63'd0, mem_req_we}, 64'd0);
    chk("rst_req_addr", mem_req_addr, 64'd0);
    chk("rst_req_wdata", mem_req_wdata, 64'd0);
    chk("rst_req_wmask", {56'd0, mem_req_wmask}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    rst = 1'b1;

    run_op(5'b00000, 64'h1234, 64'd0, 64'd0, 0, 0, 0, got);
    chk("pass_const", got, 64'h1234);
    run_op(5'b10000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, got);
    chk("lb_const", got, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(5'b10100, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, got);
    chk("lbu_const", got, 64'h0000_0000_0000_0080);
    run_op(5'b01001, 64'h8000_0006, 64'hBEEF, 64'd0, 0, 0, 0, got);
    chk("sh_const", got, 64'd0);
    run_op(5'b10010, 64'h8000_0002, 64'd0, 64'd0, 0, 0, 0, got);
    run_op(5'b01011, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 3, 1, 2, got);
    run_op(5'b10111, 64'h8000_0000, 64'd0, 64'd0, 0, 0, 0, got);
    run_op(5'b01100, 64'h8000_0000, 64'd5, 64'd0, 0, 0, 0, got);
    run_op(5'b11000, 64'h8000_0000, 64'd5, 64'd0, 0, 0, 0, got);
    run_op(5'b10011, 64'h8000_0008, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 0, 2, 0, got);
    chk("ld_const", got, 64'hDEAD_BEEF_CAFE_F00D);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       c = {2'b00, 3'($urandom())};
        1:       c = {2'b11, 3'($urandom())};
        2, 3, 4: c = {2'b01, 3'($urandom())};
        default: c = {2'b10, 3'($urandom())};
      endcase
      a  = {$urandom(), $urandom()};
      wd = {$urandom(), $urandom()};
      rd = {$urandom(), $urandom()};
      nb = 1 << c[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
      run_op(c, a, wd, rd, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), got);
    end

    // Abort from WAIT, then a stray response must not produce output.
    @(negedge clk);
    in_valid = 1'b1; ctrl_mem = 5'b10011; addr = 64'h8000_0040;
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("abort_in_wait", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_req_addr", mem_req_addr, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_out_valid", {63'd0, out_valid}, 64'd0);
      chk("stray_in_ready", {63'd0, in_ready}, 64'd1);
      chk("stray_out_data", out_data, 64'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050133_lsu.md
# ysyx_22050133_lsu

Load/store unit sitting directly downstream of the execute stage. It accepts the execute result (effective address or ALU value) plus store data and a memory-control field. It performs at most one aligned 64-bit data-bus transaction per instruction and returns the write-back value to the next stage. All RV64I load/store widths are handled, including lane select, sign/zero extension, store byte-mask generation and misalignment detection.

## Interface
Parameters:
- None; datapath fixed at 64 bits, bus data 64 bits, byte mask 8 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute result valid
- in_ready  out  1  unit can accept; high only in IDLE
- ctrl_mem  in  5  [4] load, [3] store, [2:0] RISC-V funct3
- addr  in  64  execute result: address for ld/st, pass-through value otherwise
- wdata  in  64  store data (rs2data)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_we  out  1  1 = store
- mem_req_addr  out  64  {addr[63:3], 3'b000}
- mem_req_wdata  out  64  store data shifted to byte lane
- mem_req_wmask  out  8  store byte enables; 0 for loads
- mem_rsp_valid  in  1  bus response (load data or store ack)
- mem_rsp_rdata  in  64  aligned doubleword read data
- out_valid  out  1  write-back value valid
- out_ready  in  1  downstream accepts
- out_data  out  64  write-back value
- out_err  out  1  misaligned or illegal access

## Operation
- Four-state FSM: IDLE, REQ, WAIT, RESP. The input is latched on the in_valid && in_ready handshake.
- **IDLE:** in_ready=1. On handshake:
  - Neither load nor store → RESP, with out_data=addr and out_err=0.
  - Both load and store, load funct3=111, or store funct3[2]=1 → RESP, with out_err=1 and out_data=0.
  - Misaligned access → RESP, with out_err=1, out_data=0, and no bus request. Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
  - Otherwise → REQ.
- **REQ:** mem_req_valid=1.
  - On mem_req_ready → WAIT.
  - All mem_req_* outputs are constant while mem_req_valid=1 and mem_req_ready=0.
- **WAIT:** on mem_rsp_valid → RESP.
  - Load: let lane = rdata >> (addr[2:0]*8). lb/lh/lw sign-extend lane[7:0]/[15:0]/[31:0]; lbu/lhu/lwu zero-extend; ld returns rdata unchanged.
  - Store: out_data=0.
- **RESP:** out_valid=1. On out_ready → IDLE. out_data and out_err are constant while out_valid=1.
- Store mask: sb 0x01<<addr[2:0], sh 0x03<<addr[2:0], sw 0x0F<<addr[2:0], sd 0xFF.
- Store data: mem_req_wdata = wdata << (addr[2:0]*8), truncated to 64 bits.
- mem_rsp_valid outside WAIT is ignored.
- No bypass: a new input is never accepted in the cycle the previous output retires; the unit returns to IDLE first.

## Timing
- Reset values: state IDLE, in_ready=1, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0, out_valid=0, out_data=0, out_err=0. All latched registers are 0.
- Reset mid-operation: the FSM aborts to IDLE asynchronously and mem_req_valid/out_valid drop immediately. A later stray mem_rsp_valid produces no output.
- Latency, non-memory or error path: accept in cycle 0, out_valid in cycle 1.
- Latency, memory op with zero-wait bus: accept in cycle 0, REQ in cycle 1 (ready sampled), WAIT in cycle 2 (rsp sampled), out_valid in cycle 3.
- Throughput: one instruction per (latency + 1) cycles minimum, because of the return to IDLE.
- A response arriving in the same cycle as mem_req_ready is not sampled. The bus must respond one or more cycles after accept.
- Outputs are registered or decoded from registered state only. No combinational path from in_* to out_* or mem_req_*.

## Test plan
- Pass-through: ctrl_mem=0, addr=0x1234, in_valid=1 → out_valid next cycle, out_data=0x1234, out_err=0, mem_req_valid never asserted.
- Load extension: addr=0x80000003, rdata=0x0000_0000_8000_0000, bus zero-wait:
  - lb (funct3=000) → out_data=0xFFFF_FFFF_FFFF_FF80, out_valid in cycle 3.
  - Repeat with lbu (100) → 0x0000_0000_0000_0080.
- Store lane: sh (funct3=001), addr=0x80000006, wdata=0xBEEF → mem_req_addr=0x80000000, mem_req_we=1, mem_req_wmask=0xC0, mem_req_wdata=0xBEEF_0000_0000_0000. After ack: out_data=0, out_err=0.
- Misaligned: lw (load, funct3=010) at addr=0x80000002 → out_err=1, out_data=0 in cycle 1, no bus request.
- Backpressure:
  - Hold mem_req_ready=0 for 3 cycles on an sd → mem_req_* constant throughout.
  - Then hold out_ready=0 for 2 cycles → out_valid and out_data held, in_ready=0 until the out handshake.
- Reset abort: deassert rst (drive low) while in WAIT, release, then pulse mem_rsp_valid → no out_valid, in_ready=1, state IDLE.
